// File: rtl/key_debounce_array.sv
// key_debounce_array: N_KEYS independent active-low key debouncers with press, release and
// long-press pulses. Optional auto-repeat pulses are built when KEY_REPEAT_EN is defined.
module key_debounce_array #(
    parameter int N_KEYS       = 4,
    parameter int FILTER_TICKS = 4096,
    parameter int LONG_TICKS   = 2048,
    parameter int REPEAT_TICKS = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TICK_EN,
    input  logic [N_KEYS-1:0] KEY_IN,
    output logic [N_KEYS-1:0] KEY_STATE,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_LONG,
    output logic [N_KEYS-1:0] KEY_REPEAT
);
    localparam int FW = $clog2((FILTER_TICKS > 2) ? FILTER_TICKS : 2);
    localparam int HW = $clog2((LONG_TICKS > 2) ? LONG_TICKS : 2);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_TICKS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);

    typedef enum logic [1:0] {UP, FILT_DN, DOWN, FILT_UP} state_t;

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    state_t            state_q [N_KEYS];
    state_t            state_d [N_KEYS];
    logic [FW-1:0]     fcnt_q [N_KEYS];
    logic [FW-1:0]     fcnt_d [N_KEYS];
    // The hold counter stops at LONG_TICKS-1; long_done marks that KEY_LONG already fired.
    logic [HW-1:0]     hcnt_q [N_KEYS];
    logic [HW-1:0]     hcnt_d [N_KEYS];
    logic [N_KEYS-1:0] long_done_q, long_done_d;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [N_KEYS-1:0] long_q, long_d;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2((REPEAT_TICKS > 2) ? REPEAT_TICKS : 2);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0]     rcnt_q [N_KEYS];
    logic [RW-1:0]     rcnt_d [N_KEYS];
    logic [N_KEYS-1:0] repeat_q, repeat_d;
`else
    localparam int unused_repeat_ticks = REPEAT_TICKS;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            level_q     <= '1;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            long_done_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= UP;
                fcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
            end
`ifdef KEY_REPEAT_EN
            repeat_q <= '0;
            for (int i = 0; i < N_KEYS; i++) rcnt_q[i] <= '0;
`endif
        end else begin
            sync1_q     <= KEY_IN;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            long_done_q <= long_done_d;
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            hcnt_q      <= hcnt_d;
`ifdef KEY_REPEAT_EN
            repeat_q <= repeat_d;
            rcnt_q   <= rcnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
`ifdef KEY_REPEAT_EN
        rcnt_d   = rcnt_q;
        repeat_d = '0;
`endif
        for (int i = 0; i < N_KEYS; i++) begin
            case (state_q[i])
                UP: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = FILT_DN;
                        fcnt_d[i]  = '0;
                    end
                end
                FILT_DN: begin
                    if (sync2_q[i]) begin
                        state_d[i] = UP;
                        fcnt_d[i]  = '0;
                    end else if (TICK_EN) begin
                        if (fcnt_q[i] == F_LAST) begin
                            state_d[i]     = DOWN;
                            fcnt_d[i]      = '0;
                            hcnt_d[i]      = '0;
                            long_done_d[i] = 1'b0;
                            level_d[i]     = 1'b0;
                            press_d[i]     = 1'b1;
`ifdef KEY_REPEAT_EN
                            rcnt_d[i] = '0;
`endif
                        end else begin
                            fcnt_d[i] = fcnt_q[i] + 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (sync2_q[i]) begin
                        state_d[i] = FILT_UP;
                        fcnt_d[i]  = '0;
                    end else if (TICK_EN) begin
                        if (!long_done_q[i]) begin
                            if (hcnt_q[i] == H_LAST) begin
                                long_d[i]      = 1'b1;
                                long_done_d[i] = 1'b1;
                            end else begin
                                hcnt_d[i] = hcnt_q[i] + 1'b1;
                            end
                        end
`ifdef KEY_REPEAT_EN
                        else if (rcnt_q[i] == R_LAST) begin
                            repeat_d[i] = 1'b1;
                            rcnt_d[i]   = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
`endif
                    end
                end
                FILT_UP: begin
                    // Abort keeps hold/long/repeat progress so a release bounce is invisible.
                    if (!sync2_q[i]) begin
                        state_d[i] = DOWN;
                        fcnt_d[i]  = '0;
                    end else if (TICK_EN) begin
                        if (fcnt_q[i] == F_LAST) begin
                            state_d[i]     = UP;
                            fcnt_d[i]      = '0;
                            hcnt_d[i]      = '0;
                            long_done_d[i] = 1'b0;
                            level_d[i]     = 1'b1;
                            release_d[i]   = 1'b1;
`ifdef KEY_REPEAT_EN
                            rcnt_d[i] = '0;
`endif
                        end else begin
                            fcnt_d[i] = fcnt_q[i] + 1'b1;
                        end
                    end
                end
                default: state_d[i] = UP;
            endcase
        end
    end

    assign KEY_STATE   = level_q;
    assign KEY_PRESS   = press_q;
    assign KEY_RELEASE = release_q;
    assign KEY_LONG    = long_q;
`ifdef KEY_REPEAT_EN
    assign KEY_REPEAT  = repeat_q;
`else
    assign KEY_REPEAT  = '0;
`endif

endmodule
